// File: rtl/ark_pkg.sv
// Shared types and default geometry for the lane-serial AddRoundKey engine.
package ark_pkg;
    localparam int ARK_DATA_W   = 128;
    localparam int ARK_LANE_W   = 32;
    localparam int ARK_NUM_KEYS = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ark_state_e;
endpackage

// File: rtl/ark_key_table.sv
// Round-key register file: one synchronous write port, one combinational read port.
// Reads of indices at or beyond NUM_KEYS return an all-zero key.
module ark_key_table #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 15,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    localparam logic [IDX_W:0] NUM_KEYS_L = (IDX_W+1)'(NUM_KEYS);

    logic [DATA_W-1:0] mem_q [NUM_KEYS];
    logic [DATA_W-1:0] mem_d [NUM_KEYS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_idx} < NUM_KEYS_L)) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < NUM_KEYS_L) begin
            rd_data = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/ark_lane_engine.sv
// Lane-serial AddRoundKey: XORs one LANE_W slice of the block with a snapshotted round key per cycle.
// Define ARK_STATUS_EN to add err (out-of-range round) and blk_cnt (delivered blocks) status ports.
module ark_lane_engine
    import ark_pkg::*;
#(
    parameter int DATA_W   = ARK_DATA_W,
    parameter int LANE_W   = ARK_LANE_W,
    parameter int NUM_KEYS = ARK_NUM_KEYS,
    localparam int IDX_W   = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [IDX_W-1:0]  in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_state,
    output logic              busy
`ifdef ARK_STATUS_EN
    ,
    output logic              err,
    output logic [15:0]       blk_cnt
`endif
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    ark_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [CNT_W-1:0]  lane_q, lane_d;
    logic [DATA_W-1:0] tbl_rd_data;
    logic              accept;
    logic              round_ok;
    logic              last_lane;

    ark_key_table #(
        .DATA_W   (DATA_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_key_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (key_wr_en),
        .wr_idx  (key_wr_idx),
        .wr_data (key_wr_data),
        .rd_idx  (in_round),
        .rd_data (tbl_rd_data)
    );

    assign accept    = in_valid && (state_q == IDLE);
    assign last_lane = (lane_q == CNT_W'(LANES - 1));

`ifdef ARK_STATUS_EN
    localparam logic [IDX_W:0] NUM_KEYS_L = (IDX_W+1)'(NUM_KEYS);
    assign round_ok = ({1'b0, in_round} < NUM_KEYS_L);
`else
    // Out-of-range rounds read back a zero key from the table, so the block passes through.
    assign round_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && round_ok) state_d = RUN;
            RUN:     if (last_lane) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    // The key is snapshotted at accept, so later table writes never touch a block in flight.
    always_comb begin
        data_d = data_q;
        key_d  = key_q;
        lane_d = lane_q;
        if (accept && round_ok) begin
            data_d = in_state;
            key_d  = tbl_rd_data;
            lane_d = '0;
        end else if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_q == CNT_W'(l)) begin
                    data_d[l*LANE_W +: LANE_W] = data_q[l*LANE_W +: LANE_W] ^ key_q[l*LANE_W +: LANE_W];
                end
            end
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            key_q  <= '0;
            lane_q <= '0;
        end else begin
            data_q <= data_d;
            key_q  <= key_d;
            lane_q <= lane_d;
        end
    end

    assign out_state = data_q;

`ifdef ARK_STATUS_EN
    logic        err_q, err_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        err_d     = accept && !round_ok;
        blk_cnt_d = blk_cnt_q;
        if (out_valid && out_ready) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign err     = err_q;
    assign blk_cnt = blk_cnt_q;
`endif
endmodule

// File: tb/tb_ark_lane_engine.sv
// Directed bench: 4-lane engine (a) carries most scenarios, single-lane engine (b) checks 1-cycle latency.
module tb_ark_lane_engine;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_wr_en = 1'b0;
    logic [3:0]   key_wr_idx = '0;
    logic [127:0] key_wr_data = '0;
    logic [127:0] in_state = '0;
    logic [3:0]   in_round = '0;

    logic         a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic         a_in_ready, a_out_valid, a_busy;
    logic [127:0] a_out_state;
    logic         b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [127:0] b_out_state;
`ifdef ARK_STATUS_EN
    logic         a_err, b_err;
    logic [15:0]  a_blk_cnt, b_blk_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K3   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] S3   = 128'hffff0000ffff0000ffff0000ffff0000;
    localparam logic [127:0] K3B  = {4{32'h55555555}};

    always #5 clk = ~clk;

    ark_lane_engine #(.LANE_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state), .busy(a_busy)
`ifdef ARK_STATUS_EN
        , .err(a_err), .blk_cnt(a_blk_cnt)
`endif
    );

    ark_lane_engine #(.LANE_W(128)) dut_b (
        .clk(clk), .reset(reset),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state), .busy(b_busy)
`ifdef ARK_STATUS_EN
        , .err(b_err), .blk_cnt(b_blk_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_key(input logic [3:0] idx, input logic [127:0] dat);
        key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = dat;
        tick();
        key_wr_en = 1'b0;
    endtask

    // Send one block to engine a, expect it after 4 cycles, then drain it.
    task automatic run_a(input logic [127:0] st, input logic [3:0] rd, input logic [127:0] exp, input string tag);
        int cnt;
        in_state = st; in_round = rd; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        cnt = 0;
        while (!a_out_valid && cnt < 20) begin tick(); cnt++; end
        chk({tag, "_lat"}, 128'(cnt), 128'd4);
        chk({tag, "_data"}, a_out_state, exp);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk({tag, "_drain"}, 128'(a_out_valid), 128'd0);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready", 128'(a_in_ready), 128'd1);
        chk("rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_out_state", a_out_state, 128'd0);

        // Reference vector, 4 lanes
        wr_key(4'd0, KEY0);
        in_state = PT; in_round = 4'd0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("run_in_ready", 128'(a_in_ready), 128'd0);
        chk("run_busy", 128'(a_busy), 128'd1);
        n = 0;
        while (!a_out_valid && n < 20) begin tick(); n++; end
        chk("vec32_lat", 128'(n), 128'd4);
        chk("vec32_data", a_out_state, CT);

        // Backpressure: hold for 10 cycles with in_valid pulses
        for (int i = 0; i < 10; i++) begin
            a_in_valid = i[0];
            in_state = {4{32'(i) * 32'h01010101}};
            tick();
            chk("hold_valid", 128'(a_out_valid), 128'd1);
            chk("hold_data", a_out_state, CT);
            chk("hold_in_ready", 128'(a_in_ready), 128'd0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("release_valid", 128'(a_out_valid), 128'd0);
        chk("release_in_ready", 128'(a_in_ready), 128'd1);
        chk("release_busy", 128'(a_busy), 128'd0);

        // Reference vector, single lane
        in_state = PT; in_round = 4'd0; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 20) begin tick(); n++; end
        chk("vec128_lat", 128'(n), 128'd1);
        chk("vec128_data", b_out_state, CT);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("vec128_drain", 128'(b_out_valid), 128'd0);

        // Same-cycle write+accept, then rewrite mid-RUN: snapshot wins
        wr_key(4'd3, K3);
        key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = '1;
        in_state = S3; in_round = 4'd3; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        key_wr_data = K3B;
        tick();
        key_wr_en = 1'b0;
        n = 1;
        while (!a_out_valid && n < 20) begin tick(); n++; end
        chk("snap_lat", 128'(n), 128'd4);
        chk("snap_data", a_out_state, S3 ^ K3);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        run_a('0, 4'd3, K3B, "newkey");

`ifndef ARK_STATUS_EN
        run_a(PT, 4'd15, PT, "oob_pass");
`endif

        // Reset at lane 2 of RUN, with a competing key write and in_valid
        in_state = PT; in_round = 4'd0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick(); tick();
        reset = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = KEY0; a_in_valid = 1'b1;
        tick();
        chk("mid_rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("mid_rst_out_state", a_out_state, 128'd0);
        chk("mid_rst_busy", 128'(a_busy), 128'd0);
        reset = 1'b0; key_wr_en = 1'b0; a_in_valid = 1'b0;
        chk("post_rst_in_ready", 128'(a_in_ready), 128'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_out", 128'(a_out_valid), 128'd0);
        end

`ifdef ARK_STATUS_EN
        chk("blk_cnt_rst", 128'(a_blk_cnt), 128'd0);
        chk("err_rst", 128'(a_err), 128'd0);
        in_state = PT; in_round = 4'd15; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("err_pulse", 128'(a_err), 128'd1);
        chk("err_busy", 128'(a_busy), 128'd0);
        tick();
        chk("err_clear", 128'(a_err), 128'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("err_no_out", 128'(a_out_valid), 128'd0);
        end
`endif
        run_a(PT, 4'd0, PT, "tbl_cleared");
        run_a(S3, 4'd1, S3, "blk2");
        run_a(K3, 4'd2, K3, "blk3");
`ifdef ARK_STATUS_EN
        chk("blk_cnt_3", 128'(a_blk_cnt), 128'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ark_lane_engine.md
ARK_LANE_ENGINE -- requirements
Module: ark_lane_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 128, block width in bits.
REQ-002 SHALL have parameter LANE_W, default 32, bits XORed per cycle; DATA_W % LANE_W == 0; LANES = DATA_W/LANE_W.
REQ-003 SHALL have parameter NUM_KEYS, default 15, round-key table depth; IDX_W = $clog2(NUM_KEYS).
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: key_wr_en in 1 table write strobe; key_wr_idx in IDX_W write index; key_wr_data in DATA_W round key.
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; in_state in DATA_W; in_round in IDX_W key index.
REQ-007 SHALL have ports: out_valid out 1; out_ready in 1; out_state out DATA_W result; busy out 1, high when not IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> RUN -> HOLD -> IDLE.
REQ-009 IDLE: in_ready=1; in_valid&in_ready captures in_state, in_round, and snapshots table[in_round]; lane counter cleared; -> RUN.
REQ-010 RUN: each cycle XORs lane c (bits c*LANE_W +: LANE_W, LSB lane first) of state with same lane of snapshot key; c increments; after lane LANES-1 -> HOLD.
REQ-011 out_valid SHALL rise exactly LANES cycles after the accept edge (LANES=1: next cycle).
REQ-012 HOLD: out_valid=1, out_state stable until out_ready; out_valid&out_ready -> IDLE; no same-cycle re-accept (in_ready=0 in HOLD).
REQ-013 in_ready SHALL be 0 in RUN and HOLD; in_valid ignored there.
REQ-014 Key writes SHALL take effect every cycle regardless of state; active block uses only its snapshot.
REQ-015 Write and accept in same cycle to same index: accepted block uses the pre-write key.
REQ-016 out_state SHALL equal in_state ^ table[in_round] as of accept, bit-exact.

Reset
REQ-017 reset SHALL force IDLE, out_valid=0, out_state=0, busy=0, lane counter=0, all table entries=0 on next edge.
REQ-018 reset mid-RUN or mid-HOLD SHALL drop the block without emitting it; in_ready=1 the cycle after reset deasserts.
REQ-019 reset SHALL take priority over key_wr_en and in_valid.

Configuration
REQ-020 Macro ARK_STATUS_EN defined: adds ports err out 1 and blk_cnt out 16.
REQ-021 With ARK_STATUS_EN: in_round >= NUM_KEYS at accept -> block discarded, err pulses 1 cycle, stay IDLE; blk_cnt increments (wrapping 0xFFFF->0) on each out_valid&out_ready; both reset to 0.
REQ-022 Without ARK_STATUS_EN: no err/blk_cnt ports; out-of-range in_round uses an all-zero key (state passes unchanged).

Structure
REQ-023 Package ark_pkg SHALL hold FSM state enum (IDLE/RUN/HOLD) and default DATA_W/LANE_W/NUM_KEYS constants.
REQ-024 Sub-module ark_key_table SHALL implement the register-file table: one sync write port, one combinational read port, sync reset.

Verification
REQ-025 Load table[0]=2b7e151628aed2a6abf7158809cf4f3c, send 3243f6a8885a308d313198a2e0370734 round 0, LANE_W=32 -> out_valid 4 cycles after accept, out_state=193de3bea0f4e22b9ac68d2ae9f84808.
REQ-026 Same vector, LANE_W=128 -> out_valid 1 cycle after accept, same result.
REQ-027 Hold out_ready=0 for 10 cycles -> out_valid and out_state stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-028 Accept round 3 while writing table[3]=FF..FF same cycle, then rewrite during RUN -> result uses original table[3].
REQ-029 Assert reset at lane 2 of RUN -> no out_valid, all outputs 0, table cleared, in_ready=1 after release.
REQ-030 ARK_STATUS_EN, in_round=15 with NUM_KEYS=15 -> err 1-cycle pulse, no out_valid; then 3 good blocks -> blk_cnt=3.
